cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cobalt_pkg.sv | 11 +
 rtl/cdb_rr_arb.sv | 28 ++
 rtl/cdb_arbiter.sv | 77 +++++++
 3 files changed

// File: rtl/cobalt_pkg.sv
// cobalt_pkg: shared widths and functional-unit port indices for the common data bus.
package cobalt_pkg;
   localparam int W_TAG  = 6;
   localparam int W_DATA = 32;
   localparam int N_REQ  = 4;
   typedef logic [1:0] fu_idx_t;
   localparam fu_idx_t FU_INT = 2'd0;
   localparam fu_idx_t FU_MUL = 2'd1;
   localparam fu_idx_t FU_DIV = 2'd2;
   localparam fu_idx_t FU_LS  = 2'd3;
endpackage

// File: rtl/cdb_rr_arb.sv
// cdb_rr_arb: round-robin pick among occupied hold entries; pointer moves past each winner.
module cdb_rr_arb
   import cobalt_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_REQ-1:0] hold_v,
   output logic [N_REQ-1:0] grant,
   output fu_idx_t          grant_idx,
   output logic             grant_any
);
   fu_idx_t rr_ptr_q, rr_ptr_d, off;
   logic [2*N_REQ-1:0] dbl;
   // rotate so the search always starts at bit 0, then undo the rotation
   always_comb begin
      dbl = {hold_v, hold_v} >> rr_ptr_q;
      off = '0;
      for (int i = N_REQ-1; i >= 0; i--) if (dbl[i]) off = fu_idx_t'(i);
      grant_any = |hold_v;
      grant_idx = rr_ptr_q + off;
      grant = '0;
      grant[grant_idx] = grant_any;
      rr_ptr_d = grant_any ? grant_idx + 2'd1 : rr_ptr_q;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) rr_ptr_q <= '0;
      else rr_ptr_q <= rr_ptr_d;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: one hold entry per functional unit, round-robin onto a registered result bus.
module cdb_arbiter
   import cobalt_pkg::*;
#(
   parameter int W_TAG  = cobalt_pkg::W_TAG,
   parameter int W_DATA = cobalt_pkg::W_DATA
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*W_TAG-1:0]  req_tag,
   input  logic [N_REQ*W_DATA-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    cdb_valid,
   output logic [W_TAG-1:0]        cdb_tag,
   output logic [W_DATA-1:0]       cdb_data,
   output logic [1:0]              cdb_src
);
   logic [N_REQ-1:0] hold_v_q, hold_v_d, grant, xfer;
   logic [N_REQ-1:0][W_TAG-1:0] hold_tag_q, hold_tag_d, in_tag;
   logic [N_REQ-1:0][W_DATA-1:0] hold_data_q, hold_data_d, in_data;
   logic grant_any, cdb_valid_q, cdb_valid_d;
   fu_idx_t grant_idx, cdb_src_q, cdb_src_d;
   logic [W_TAG-1:0] cdb_tag_q, cdb_tag_d;
   logic [W_DATA-1:0] cdb_data_q, cdb_data_d;

   cdb_rr_arb u_arb (
      .clk       (clk),
      .reset_n   (reset_n),
      .hold_v    (hold_v_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   assign in_tag    = req_tag;
   assign in_data   = req_data;
   // a granted entry drains this cycle, so it can refill without a bubble
   assign req_ready = ~hold_v_q | grant;
   assign xfer      = req_valid & req_ready;

   always_comb begin
      hold_v_d = xfer | (hold_v_q & ~grant);
      for (int i = 0; i < N_REQ; i++) begin
         hold_tag_d[i]  = xfer[i] ? in_tag[i]  : hold_tag_q[i];
         hold_data_d[i] = xfer[i] ? in_data[i] : hold_data_q[i];
      end
      cdb_valid_d = grant_any;
      cdb_tag_d   = grant_any ? hold_tag_q[grant_idx]  : cdb_tag_q;
      cdb_data_d  = grant_any ? hold_data_q[grant_idx] : cdb_data_q;
      cdb_src_d   = grant_any ? grant_idx : cdb_src_q;
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         hold_v_q    <= '0;
         hold_tag_q  <= '0;
         hold_data_q <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_data_q  <= '0;
         cdb_src_q   <= '0;
      end else begin
         hold_v_q    <= hold_v_d;
         hold_tag_q  <= hold_tag_d;
         hold_data_q <= hold_data_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_data_q  <= cdb_data_d;
         cdb_src_q   <= cdb_src_d;
      end

   assign cdb_valid = cdb_valid_q;
   assign cdb_tag   = cdb_tag_q;
   assign cdb_data  = cdb_data_q;
   assign cdb_src   = cdb_src_q;
endmodule
